// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data (MEM-stage) requester. A single FSM grants one
// access at a time, holds the memory fields stable until memAck or a timeout,
// and then returns a one-cycle done pulse to the requester that was granted.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
// requesters are pending. Without it, the data requester always wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TMO_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  iValid,
    input  logic [ADDR_W-1:0]     iAddr,
    output logic                  iDone,
    output logic [DATA_W-1:0]     iRdata,
    output logic                  iErr,
    output logic                  iStall,

    input  logic                  dValid,
    input  logic                  dWe,
    input  logic [ADDR_W-1:0]     dAddr,
    input  logic [DATA_W-1:0]     dWdata,
    input  logic [DATA_W/8-1:0]   dBe,
    output logic                  dDone,
    output logic [DATA_W-1:0]     dRdata,
    output logic                  dErr,
    output logic                  dStall,

    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWdata,
    output logic [DATA_W/8-1:0]   memBe,
    input  logic [DATA_W-1:0]     memRdata,
    input  logic                  memAck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               any_req;
    logic               grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the most recent grant went to the data requester.
    logic               last_grant;
`endif

    // Stall whenever a request is pending and its completion is not being
    // signalled in this very cycle.
    assign iStall = iValid & ~iDone;
    assign dStall = dValid & ~dDone;

    assign any_req = iValid | dValid;

    // Arbitration decision in IDLE: a single pending requester always wins;
    // on contention either data wins or the requester not granted last wins.
    always_comb begin
        grant_data = dValid;
`ifdef ARB_ROUND_ROBIN_EN
        if (iValid && dValid) begin
            grant_data = ~last_grant;
        end
`endif
    end

    // Main FSM: grant, hold the memory fields while busy, then respond.
    // NOTE: every register here uses non-blocking assignments so that all
    // state updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the data-holding ones, is reset
            // so that outputs are defined immediately and an abandoned access
            // leaves nothing behind.
            state    <= IDLE;
            tmo_cnt  <= '0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            iDone    <= 1'b0;
            iErr     <= 1'b0;
            iRdata   <= '0;
            dDone    <= 1'b0;
            dErr     <= 1'b0;
            dRdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        memReq  <= 1'b1;
                        tmo_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant_data;
`endif
                        if (grant_data) begin
                            state    <= BUSY_D;
                            memWe    <= dWe;
                            memAddr  <= dAddr;
                            memWdata <= dWdata;
                            memBe    <= dBe;
                        end else begin
                            state    <= BUSY_I;
                            memWe    <= 1'b0;
                            memAddr  <= iAddr;
                            memWdata <= '0;
                            memBe    <= '1;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (memAck) begin
                        state  <= RESP;
                        memReq <= 1'b0;
                        if (state == BUSY_I) begin
                            iDone  <= 1'b1;
                            iErr   <= 1'b0;
                            iRdata <= memRdata;
                        end else begin
                            dDone <= 1'b1;
                            dErr  <= 1'b0;
                            // Stores complete without touching read data.
                            if (!memWe) begin
                                dRdata <= memRdata;
                            end
                        end
                    end else if (tmo_cnt == '1) begin
                        state  <= RESP;
                        memReq <= 1'b0;
                        if (state == BUSY_I) begin
                            iDone <= 1'b1;
                            iErr  <= 1'b1;
                        end else begin
                            dDone <= 1'b1;
                            dErr  <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    iDone <= 1'b0;
                    dDone <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                    iDone  <= 1'b0;
                    dDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset values, a minimum
// latency fetch, contention arbitration, a multi-cycle store, a timeout and
// a reset in the middle of an access.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int TMO_W  = 8;

    logic                clk;
    logic                rst;
    logic                iValid;
    logic [ADDR_W-1:0]   iAddr;
    logic                iDone;
    logic [DATA_W-1:0]   iRdata;
    logic                iErr;
    logic                iStall;
    logic                dValid;
    logic                dWe;
    logic [ADDR_W-1:0]   dAddr;
    logic [DATA_W-1:0]   dWdata;
    logic [DATA_W/8-1:0] dBe;
    logic                dDone;
    logic [DATA_W-1:0]   dRdata;
    logic                dErr;
    logic                dStall;
    logic                memReq;
    logic                memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata;
    logic [DATA_W/8-1:0] memBe;
    logic [DATA_W-1:0]   memRdata;
    logic                memAck;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iValid  (iValid),
        .iAddr   (iAddr),
        .iDone   (iDone),
        .iRdata  (iRdata),
        .iErr    (iErr),
        .iStall  (iStall),
        .dValid  (dValid),
        .dWe     (dWe),
        .dAddr   (dAddr),
        .dWdata  (dWdata),
        .dBe     (dBe),
        .dDone   (dDone),
        .dRdata  (dRdata),
        .dErr    (dErr),
        .dStall  (dStall),
        .memReq  (memReq),
        .memWe   (memWe),
        .memAddr (memAddr),
        .memWdata(memWdata),
        .memBe   (memBe),
        .memRdata(memRdata),
        .memAck  (memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; all driving and
    // sampling happens there, away from the edge itself.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [DATA_W-1:0] exp_drdata;
        logic              exp_data;
        logic              rr_next_data;
        int                k;

        rst      = 1'b1;
        iValid   = 1'b0;
        iAddr    = '0;
        dValid   = 1'b0;
        dWe      = 1'b0;
        dAddr    = '0;
        dWdata   = '0;
        dBe      = '0;
        memRdata = '0;
        memAck   = 1'b0;

        // Reset values, observed before the first clock edge.
        #2;
        check("rst_memReq", memReq, 1'b0);
        check("rst_memWe", memWe, 1'b0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_memBe", memBe, 8'h00);
        check("rst_dones", {iDone, dDone, iErr, dErr}, 4'b0000);
        check("rst_rdata", {iRdata, dRdata}, 128'h0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_no_req", memReq, 1'b0);

        // Fetch with ack latency 1.
        iValid = 1'b1;
        iAddr  = 32'h100;
        step();
        check("fetch_memReq_c1", memReq, 1'b1);
        check("fetch_memAddr", memAddr, 32'h100);
        check("fetch_memBe", memBe, 8'hFF);
        check("fetch_memWe", memWe, 1'b0);
        check("fetch_iStall_c1", iStall, 1'b1);
        memAck   = 1'b1;
        memRdata = 64'h13;
        step();
        check("fetch_iDone_c2", iDone, 1'b1);
        check("fetch_iRdata", iRdata, 64'h13);
        check("fetch_iErr", iErr, 1'b0);
        check("fetch_memReq_c2", memReq, 1'b0);
        check("fetch_iStall_c2", iStall, 1'b0);
        iValid = 1'b0;
        memAck = 1'b1;
        step();
        check("fetch_iDone_pulse", iDone, 1'b0);
        check("fetch_ack_in_idle", memReq, 1'b0);
        memAck = 1'b0;

        // Contention after a fresh reset: I at 0x200, D at 0x300.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        iValid = 1'b1;
        iAddr  = 32'h200;
        dValid = 1'b1;
        dWe    = 1'b0;
        dAddr  = 32'h300;
        dBe    = 8'hFF;
        exp_drdata   = '0;
        rr_next_data = 1'b0;
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_data     = rr_next_data;
            rr_next_data = ~rr_next_data;
`else
            exp_data = 1'b1;
`endif
            step();
            check($sformatf("cont%0d_memReq", n), memReq, 1'b1);
            check($sformatf("cont%0d_grant", n), memAddr,
                  exp_data ? 32'h300 : 32'h200);
            check($sformatf("cont%0d_iStall_busy", n), iStall, 1'b1);
            memAck   = 1'b1;
            memRdata = 64'h1000 + 64'(n);
            step();
            check($sformatf("cont%0d_done", n), {iDone, dDone},
                  exp_data ? 2'b01 : 2'b10);
            check($sformatf("cont%0d_iStall_resp", n), iStall, exp_data);
            if (exp_data) begin
                exp_drdata = 64'h1000 + 64'(n);
                check($sformatf("cont%0d_dRdata", n), dRdata, exp_drdata);
            end else begin
                check($sformatf("cont%0d_iRdata", n), iRdata,
                      64'h1000 + 64'(n));
            end
            memAck = 1'b0;
            step();
            check($sformatf("cont%0d_idle_memReq", n), memReq, 1'b0);
        end
        iValid = 1'b0;
        dValid = 1'b0;
        step();

        // Store with ack latency 4.
        dValid = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h400;
        dWdata = 64'hAA;
        dBe    = 8'h0F;
        step();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("st_c%0d_fields", c), {memReq, memWe, memBe},
                  {1'b1, 1'b1, 8'h0F});
            check($sformatf("st_c%0d_wdata", c), memWdata, 64'hAA);
            check($sformatf("st_c%0d_dDone", c), dDone, 1'b0);
            if (c < 4) step();
        end
        memAck   = 1'b1;
        memRdata = 64'hDEAD_BEEF;
        step();
        check("st_dDone", dDone, 1'b1);
        check("st_dErr", dErr, 1'b0);
        check("st_dRdata_kept", dRdata, exp_drdata);
        check("st_memReq_resp", memReq, 1'b0);
        memAck = 1'b0;
        dValid = 1'b0;
        dWe    = 1'b0;
        step();

        // Timeout: no memAck, read from 0x500.
        dValid = 1'b1;
        dAddr  = 32'h500;
        step();
        k = 0;
        while (dDone !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check("tmo_cycles", 64'(k), 64'd256);
        check("tmo_dErr", dErr, 1'b1);
        check("tmo_memReq_resp", memReq, 1'b0);
        check("tmo_dRdata_kept", dRdata, exp_drdata);
        dValid = 1'b0;
        step();
        check("tmo_dDone_pulse", dDone, 1'b0);

        // Reset in BUSY_D, then a late memAck.
        dValid = 1'b1;
        dAddr  = 32'h600;
        step();
        check("rstmid_busy", memReq, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_memReq_now", memReq, 1'b0);
        #1;
        rst      = 1'b0;
        dValid   = 1'b0;
        memAck   = 1'b1;
        memRdata = 64'h55;
        step();
        check("rstmid_no_done1", {dDone, memReq}, 2'b00);
        check("rstmid_dRdata", dRdata, 64'h0);
        memAck = 1'b0;
        step();
        check("rstmid_no_done2", {dDone, memReq}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
